// File: rtl/apb_master.sv
// APB requester: valid/ready command in, SETUP/ACCESS transfers out,
// registered one-cycle response with slave-error and wait-state timeout.
module apb_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk_m,
  input  logic          prst_m,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          psel_m,
  output logic          penable_m,
  output logic          pwrite_m,
  output logic [AW-1:0] paddress_m,
  output logic [DW-1:0] pwdata_m,
  input  logic [DW-1:0] prdata_m,
  input  logic          pready_m,
  input  logic          pslverr_m,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          in_access;
  logic          expire;
  logic          done;
  logic          hs;

  assign in_access = (state == ACCESS);

  // Expiry on the TIMEOUT-th consecutive stalled ACCESS cycle
  assign expire = (TIMEOUT != 0) && in_access && !pready_m
                  && (wait_cnt == CW'(TIMEOUT - 1));

  assign done      = in_access && (pready_m || expire);
  assign cmd_ready = prst_m && ((state == IDLE) || done);
  assign hs        = cmd_valid && cmd_ready;
  assign psel_m    = (state != IDLE);
  assign penable_m = in_access;

  always_ff @(posedge pclk_m) begin
    if (!prst_m) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = hs ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk_m) begin
    if (!prst_m) begin
      pwrite_m    <= 1'b0;
      paddress_m  <= '0;
      pwdata_m    <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (hs) begin
        pwrite_m   <= cmd_write;
        paddress_m <= cmd_addr;
        pwdata_m   <= cmd_wdata;
      end
      if (state == SETUP)
        wait_cnt <= '0;
      else if (in_access && !pready_m && (wait_cnt != '1))
        wait_cnt <= wait_cnt + 1'b1;
      rsp_valid   <= done;
      rsp_rdata   <= (done && pready_m && !pwrite_m) ? prdata_m : '0;
      rsp_err     <= done && (!pready_m || pslverr_m);
      rsp_timeout <= done && !pready_m;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: random commands, modelled completer,
// expected responses queued at handshake and checked by a monitor.
module tb_apb_master;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  always #5 clk = ~clk;

  apb_master #(.AW(32), .DW(32), .TIMEOUT(T)) dut (
    .pclk_m     (clk),
    .prst_m     (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .psel_m     (psel),
    .penable_m  (penable),
    .pwrite_m   (pwrite),
    .paddress_m (paddr),
    .pwdata_m   (pwdata),
    .prdata_m   (prdata),
    .pready_m   (pready),
    .pslverr_m  (pslverr),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout)
  );

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        err;
  } xfer_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          due;
  } rsp_t;

  xfer_t xq[$];
  rsp_t  rq[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Completer stalls `waits` ACCESS cycles; T stalls in a row abort.
  function automatic rsp_t model(xfer_t x, int c);
    rsp_t r;
    if (x.waits >= T) begin
      r.rdata = '0;
      r.err   = 1'b1;
      r.to    = 1'b1;
      r.due   = c + 2 + T;
    end else begin
      r.rdata = x.w ? 32'h0 : x.rdata;
      r.err   = x.err;
      r.to    = 1'b0;
      r.due   = c + 3 + x.waits;
    end
    return r;
  endfunction

  function automatic xfer_t mk(logic w, logic [31:0] a,
                               logic [31:0] wd, logic [31:0] rd,
                               int waits, logic err);
    xfer_t x;
    x.w = w; x.addr = a; x.wdata = wd;
    x.rdata = rd; x.waits = waits; x.err = err;
    return x;
  endfunction

  function automatic xfer_t rand_x();
    int sel;
    int waits;
    sel = $urandom_range(0, 9);
    if (sel < 5)      waits = 0;
    else if (sel < 8) waits = $urandom_range(1, 3);
    else              waits = $urandom_range(4, 7);
    return mk(1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom, waits, ($urandom_range(0, 3) == 0));
  endfunction

  task automatic issue(xfer_t x);
    bit hs;
    int c;
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = x.w;
    cmd_addr  = x.addr;
    cmd_wdata = x.wdata;
    forever begin
      #4;
      hs = cmd_ready;
      c  = cyc;
      @(posedge clk);
      if (hs) begin
        xq.push_back(x);
        rq.push_back(model(x, c));
        break;
      end
      n++;
      if (n > 100) begin
        flag("handshake_timeout");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(int n);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() > 0) flag("drain_timeout");
  endtask

  // Completer model
  int    k = 0;
  bit    have = 0;
  xfer_t cur;

  always @(negedge clk) begin
    pready  = 1'($urandom_range(0, 1));
    pslverr = 1'($urandom_range(0, 1));
    prdata  = $urandom;
    if (psel && !penable) begin
      k = 0;
    end else if (psel && penable) begin
      k++;
      if (k == 1) begin
        if (xq.size() == 0) begin
          flag("access_without_cmd");
          have = 0;
        end else begin
          cur  = xq.pop_front();
          have = 1;
        end
      end
      if (have) begin
        check("paddr", 64'(paddr), 64'(cur.addr));
        check("pwrite", 64'(pwrite), 64'(cur.w));
        if (cur.w) check("pwdata", 64'(pwdata), 64'(cur.wdata));
        pready = (k == cur.waits + 1);
        if (pready) begin
          prdata  = cur.rdata;
          pslverr = cur.err;
        end
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin : mon
    rsp_t r;
    if (rsp_valid) begin
      if (rq.size() == 0) begin
        flag("unexpected_rsp");
      end else begin
        r = rq.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
        check("rsp_err", 64'(rsp_err), 64'(r.err));
        check("rsp_timeout", 64'(rsp_timeout), 64'(r.to));
        check("rsp_cycle", 64'(cyc), 64'(r.due));
      end
    end
  end

  initial begin
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psel", 64'(psel), 0);
    check("rst_penable", 64'(penable), 0);
    check("rst_pwrite", 64'(pwrite), 0);
    check("rst_paddr", 64'(paddr), 0);
    check("rst_pwdata", 64'(pwdata), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 0);
    check("rst_rsp_err", 64'(rsp_err), 0);
    check("rst_rsp_timeout", 64'(rsp_timeout), 0);
    check("rst_cmd_ready", 64'(cmd_ready), 0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    idle(2);

    issue(mk(1, 32'd3, 32'hDEAD_BEEF, 32'h0, 0, 0));
    idle(2);
    issue(mk(0, 32'd5, 32'h0, 32'h1234_5678, 2, 0));
    idle(1);
    issue(mk(1, 32'h10, 32'hA5A5_0001, 32'h0, 0, 0));
    issue(mk(0, 32'h14, 32'h0, 32'h0BAD_F00D, 0, 0));
    idle(2);
    issue(mk(0, 32'h20, 32'h0, 32'hCAFE_0042, 0, 1));
    idle(2);
    drain();

    issue(mk(0, 32'h30, 32'h0, 32'h7777_7777, 9, 0));
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (T + 1) @(negedge clk);
    check("to_rsp_valid", 64'(rsp_valid), 1);
    check("to_psel", 64'(psel), 0);
    check("to_cmd_ready", 64'(cmd_ready), 1);
    drain();

    issue(mk(0, 32'h40, 32'h0, 32'h5555_AAAA, 3, 0));
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_access", 64'({psel, penable}), 64'(2'b11));
    rst_n = 1'b0;
    if (rq.size() > 0) rq.delete(rq.size() - 1);
    @(negedge clk);
    check("mid_rst_psel", 64'(psel), 0);
    check("mid_rst_penable", 64'(penable), 0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 0);
    rst_n = 1'b1;
    idle(3);
    issue(mk(1, 32'h44, 32'h0123_4567, 32'h0, 1, 0));
    idle(1);
    drain();

    for (int i = 0; i < 300; i++) begin
      issue(rand_x());
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    drain();
    repeat (5) @(negedge clk);
    if (xq.size() != 0) flag("leftover_xfer");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
